// File: rtl/fixed_matmul_in2_replay_buffer_pkg.sv
// Shared sizing helpers for the data_in2 replay buffer.
// Keeps counter and index widths legal even when a depth or repeat count is 1.
package fixed_matmul_in2_replay_buffer_pkg;

  // Counters need one spare bit so the value N-1 always fits, including N=1.
  function automatic int ctr_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Width of a memory index; a one-entry array still needs a 1-bit select.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fixed_matmul_in2_replay_buffer.sv
// Captures one B column-block of IN_DEPTH tiles and replays it REPEAT times
// to the matmul core's data_in2 port, bit-exact, with no fill/replay overlap.
module fixed_matmul_in2_replay_buffer
  import fixed_matmul_in2_replay_buffer_pkg::*;
#(
  parameter int IN2_WIDTH       = 8,
  parameter int IN_SIZE         = 1,
  parameter int IN2_PARALLELISM = 3,
  parameter int IN_DEPTH        = 3,
  parameter int REPEAT          = 2,
  localparam int TILE           = IN_SIZE * IN2_PARALLELISM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN2_WIDTH-1:0] data_in [TILE-1:0],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [IN2_WIDTH-1:0] data_out [TILE-1:0],
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 busy
);

  localparam int PW = ctr_width(IN_DEPTH);
  localparam int RW = ctr_width(REPEAT);
  localparam int IW = idx_width(IN_DEPTH);

  localparam logic [PW-1:0] LAST_PTR = PW'(IN_DEPTH - 1);
  localparam logic [RW-1:0] LAST_REP = RW'(REPEAT - 1);

  typedef enum logic {
    FILL,
    REPLAY
  } state_t;

  state_t                 state;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [RW-1:0]          rep_cnt;
  logic [IN2_WIDTH-1:0]   mem [IN_DEPTH-1:0][TILE-1:0];

  logic in_fire;
  logic out_fire;

  assign in_fire  = data_in_valid && data_in_ready;
  assign out_fire = data_out_valid && data_out_ready;

  // Storage is intentionally not reset; a block is only replayed once fully written.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_ptr[IW-1:0]] <= data_in;
    end
  end

  assign data_out = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rep_cnt        <= '0;
      data_in_ready  <= 1'b0;
      data_out_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          data_in_ready <= 1'b1;
          if (in_fire) begin
            if (wr_ptr == LAST_PTR) begin
              wr_ptr         <= '0;
              state          <= REPLAY;
              data_in_ready  <= 1'b0;
              data_out_valid <= 1'b1;
              busy           <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        REPLAY: begin
          // Backpressure simply holds both counters, which keeps data_out stable.
          if (out_fire) begin
            if (rd_ptr == LAST_PTR) begin
              rd_ptr <= '0;
              if (rep_cnt == LAST_REP) begin
                rep_cnt        <= '0;
                state          <= FILL;
                data_in_ready  <= 1'b1;
                data_out_valid <= 1'b0;
                busy           <= 1'b0;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end
        end
        default: begin
          state          <= FILL;
          data_in_ready  <= 1'b0;
          data_out_valid <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_matmul_in2_replay_buffer.sv
// Scoreboard bench: default-parameter buffer plus a one-tile, single-replay buffer.
// Expected tiles are queued at stimulus time and popped by per-DUT output monitors.
module tb_fixed_matmul_in2_replay_buffer;

  logic clk;
  logic rst;

  logic [7:0] din_a [2:0];
  logic       in_valid_a, in_ready_a;
  logic [7:0] dout_a [2:0];
  logic       out_valid_a, out_ready_a, busy_a;

  logic [7:0] din_b [2:0];
  logic       in_valid_b, in_ready_b;
  logic [7:0] dout_b [2:0];
  logic       out_valid_b, out_ready_b, busy_b;

  int checks   = 0;
  int failures = 0;

  logic [23:0] sb_a [$];
  logic [23:0] sb_b [$];

  fixed_matmul_in2_replay_buffer #(
    .IN2_WIDTH(8), .IN_SIZE(1), .IN2_PARALLELISM(3), .IN_DEPTH(3), .REPEAT(2)
  ) dut_a (
    .clk(clk), .rst(rst),
    .data_in(din_a), .data_in_valid(in_valid_a), .data_in_ready(in_ready_a),
    .data_out(dout_a), .data_out_valid(out_valid_a), .data_out_ready(out_ready_a),
    .busy(busy_a)
  );

  fixed_matmul_in2_replay_buffer #(
    .IN2_WIDTH(8), .IN_SIZE(1), .IN2_PARALLELISM(3), .IN_DEPTH(1), .REPEAT(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .data_in(din_b), .data_in_valid(in_valid_b), .data_in_ready(in_ready_b),
    .data_out(dout_b), .data_out_valid(out_valid_b), .data_out_ready(out_ready_b),
    .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pack3(input logic [7:0] t [2:0]);
    return {t[2], t[1], t[0]};
  endfunction

  function automatic logic [23:0] tile(input logic [7:0] e0, input logic [7:0] e1,
                                       input logic [7:0] e2);
    return {e2, e1, e0};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor for the default buffer: pops on each handshake and enforces hold-while-stalled.
  logic        held_a_v = 1'b0;
  logic [23:0] held_a;
  always @(negedge clk) begin
    if (rst) begin
      held_a_v = 1'b0;
    end else begin
      if (held_a_v) begin
        check_output("a_hold_valid", {31'd0, out_valid_a}, 32'd1);
        check_output("a_hold_data", {8'd0, pack3(dout_a)}, {8'd0, held_a});
      end
      if (out_valid_a && out_ready_a) begin
        held_a_v = 1'b0;
        if (sb_a.size() == 0) begin
          check_output("a_unexpected_out", {8'd0, pack3(dout_a)}, 32'hFFFF_FFFF);
        end else begin
          check_output("a_out_tile", {8'd0, pack3(dout_a)}, {8'd0, sb_a.pop_front()});
        end
      end else if (out_valid_a) begin
        held_a_v = 1'b1;
        held_a   = pack3(dout_a);
      end else begin
        held_a_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (sb_b.size() == 0) begin
        check_output("b_unexpected_out", {8'd0, pack3(dout_b)}, 32'hFFFF_FFFF);
      end else begin
        check_output("b_out_tile", {8'd0, pack3(dout_b)}, {8'd0, sb_b.pop_front()});
      end
    end
  end

  // Presents one tile to the default buffer and returns just after it is accepted.
  task automatic apply_stimulus(input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2);
    int t;
    din_a[0] = e0; din_a[1] = e1; din_a[2] = e2;
    in_valid_a = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready_a && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) check_output("a_in_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid_a = 1'b0;
  endtask

  task automatic push_block_twice(input logic [23:0] t0, input logic [23:0] t1,
                                  input logic [23:0] t2);
    for (int r = 0; r < 2; r++) begin
      sb_a.push_back(t0); sb_a.push_back(t1); sb_a.push_back(t2);
    end
  endtask

  task automatic drain_a(input string name);
    int t;
    t = 0;
    while (sb_a.size() != 0 && t < 200) begin
      t++;
      @(posedge clk);
    end
    if (t >= 200) check_output({name, "_drain_timeout"}, sb_a.size(), 32'd0);
    @(negedge clk);
    check_output({name, "_ready_after"}, {31'd0, in_ready_a}, 32'd1);
    check_output({name, "_busy_after"}, {31'd0, busy_a}, 32'd0);
    check_output({name, "_valid_after"}, {31'd0, out_valid_a}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    din_a[0] = 8'hAA; din_a[1] = 8'hBB; din_a[2] = 8'hCC;
    in_valid_b = 1'b0; out_ready_b = 1'b1;
    din_b[0] = 8'h00; din_b[1] = 8'h00; din_b[2] = 8'h00;

    // T1: reset with upstream valid held high
    repeat (2) begin
      @(negedge clk);
      check_output("t1_valid_in_reset", {31'd0, out_valid_a}, 32'd0);
      check_output("t1_busy_in_reset", {31'd0, busy_a}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0; in_valid_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("t1_ready_after_release", {31'd0, in_ready_a}, 32'd1);
    check_output("t1_valid_after_release", {31'd0, out_valid_a}, 32'd0);
    check_output("t1_busy_after_release", {31'd0, busy_a}, 32'd0);
    @(posedge clk);
    #1;

    // T2 + T3: default block, with a 3-cycle stall on the 2nd replayed tile
    apply_stimulus(8'd1, 8'd2, 8'd3);
    apply_stimulus(8'd4, 8'd5, 8'd6);
    apply_stimulus(8'd7, 8'd8, 8'd9);
    push_block_twice(tile(1, 2, 3), tile(4, 5, 6), tile(7, 8, 9));
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (sb_a.size() > 5 && t < 50);
    #1 out_ready_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("t3_stalled_tile", {8'd0, pack3(dout_a)}, {8'd0, tile(4, 5, 6)});
      check_output("t3_stalled_valid", {31'd0, out_valid_a}, 32'd1);
      check_output("t3_stalled_busy", {31'd0, busy_a}, 32'd1);
    end
    @(posedge clk);
    #1 out_ready_a = 1'b1;
    drain_a("t2");

    // T4: gapped fill; replay must not start before the 3rd accept, and writes during replay are ignored
    apply_stimulus(8'd21, 8'd22, 8'd23);
    @(negedge clk);
    check_output("t4_no_early_replay1", {31'd0, out_valid_a}, 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(8'd24, 8'd25, 8'd26);
    @(negedge clk);
    check_output("t4_no_early_replay2", {31'd0, out_valid_a}, 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(8'd27, 8'd28, 8'd29);
    push_block_twice(tile(21, 22, 23), tile(24, 25, 26), tile(27, 28, 29));
    @(negedge clk);
    check_output("t4_first_valid_latency", {31'd0, out_valid_a}, 32'd1);
    check_output("t4_busy_in_replay", {31'd0, busy_a}, 32'd1);
    check_output("t4_ready_low_in_replay", {31'd0, in_ready_a}, 32'd0);
    @(posedge clk);
    #1 din_a[0] = 8'd99; din_a[1] = 8'd99; din_a[2] = 8'd99; in_valid_a = 1'b1;
    t = 0;
    while (sb_a.size() > 1 && t < 50) begin
      t++;
      @(posedge clk);
    end
    #1 in_valid_a = 1'b0;
    drain_a("t4");

    // T5: reset after 4 replayed tiles, then a fresh block
    apply_stimulus(8'd31, 8'd32, 8'd33);
    apply_stimulus(8'd34, 8'd35, 8'd36);
    apply_stimulus(8'd37, 8'd38, 8'd39);
    push_block_twice(tile(31, 32, 33), tile(34, 35, 36), tile(37, 38, 39));
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (sb_a.size() > 2 && t < 50);
    #1 rst = 1'b1;
    sb_a.delete();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output("t5_valid_in_reset", {31'd0, out_valid_a}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply_stimulus(8'd10, 8'd11, 8'd12);
    apply_stimulus(8'd13, 8'd14, 8'd15);
    apply_stimulus(8'd16, 8'd17, 8'd18);
    push_block_twice(tile(10, 11, 12), tile(13, 14, 15), tile(16, 17, 18));
    drain_a("t5");

    // T6: one-tile, single-replay buffer; upstream stays valid so alternation is forced by the DUT
    din_b[0] = 8'h7F; din_b[1] = 8'h7F; din_b[2] = 8'h7F;
    in_valid_b = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready_b && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) check_output("t6_in_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 din_b[0] = 8'h80; din_b[1] = 8'h80; din_b[2] = 8'h80;
    sb_b.push_back(tile(8'h7F, 8'h7F, 8'h7F));
    @(negedge clk);
    check_output("t6_ready_low_after_fill", {31'd0, in_ready_b}, 32'd0);
    check_output("t6_valid_after_fill", {31'd0, out_valid_b}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("t6_ready_after_out", {31'd0, in_ready_b}, 32'd1);
    check_output("t6_valid_low_after_out", {31'd0, out_valid_b}, 32'd0);
    sb_b.push_back(tile(8'h80, 8'h80, 8'h80));
    @(posedge clk);
    #1 in_valid_b = 1'b0;
    @(negedge clk);
    check_output("t6_valid_second", {31'd0, out_valid_b}, 32'd1);
    check_output("t6_ready_low_second", {31'd0, in_ready_b}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("t6_valid_low_end", {31'd0, out_valid_b}, 32'd0);
    check_output("t6_ready_end", {31'd0, in_ready_b}, 32'd1);

    repeat (3) @(posedge clk);
    check_output("sb_a_empty", sb_a.size(), 32'd0);
    check_output("sb_b_empty", sb_b.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
